// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared encodings and helpers for the memory arbiter
package mem_arbiter_pkg;
  typedef enum logic [1:0] {
    ARB_IDLE   = 2'b00,
    ARB_GNT_IF = 2'b01,
    ARB_GNT_LS = 2'b10
  } arb_state_e;
  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_IF   = 2'b01;
  localparam logic [1:0] GRANT_LS   = 2'b10;
  localparam int ARB_RR      = 0;
  localparam int ARB_LS_PRIO = 1;
  function automatic int cnt_width(input int t);
    return t > 0 ? $clog2(t + 1) : 1;
  endfunction
endpackage

// File: rtl/arb_watchdog.sv
// arb_watchdog: saturating stall counter that flags an abort for an unacknowledged grant
module arb_watchdog
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic busy,
  input  logic ready,
  output logic abort
);
  localparam int CW = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk) begin
    if (!rst_n) cnt <= '0;
    else if (!busy || ready || abort) cnt <= '0;
    else if (cnt != TMAX) cnt <= cnt + CW'(1);
  end
  assign abort = (TIMEOUT_CYCLES > 0) && busy && !ready && (cnt == TMAX);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between fetch and LSU with fixed-priority or round-robin grants
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int ARB_MODE       = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    if_valid_i,
  output logic                    if_ready_o,
  input  logic [ADDR_WIDTH-1:0]   if_addr_i,
  input  logic [DATA_WIDTH-1:0]   if_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] if_we_i,
  output logic [DATA_WIDTH-1:0]   if_rdata_o,
  output logic                    if_err_o,
  input  logic                    ls_valid_i,
  output logic                    ls_ready_o,
  input  logic [ADDR_WIDTH-1:0]   ls_addr_i,
  input  logic [DATA_WIDTH-1:0]   ls_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] ls_we_i,
  output logic [DATA_WIDTH-1:0]   ls_rdata_o,
  output logic                    ls_err_o,
  output logic                    mem_valid_o,
  input  logic                    mem_ready_i,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0] mem_we_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  output logic [1:0]              grant_o
);
  arb_state_e state_q, state_d, idle_d, other_d;
  logic last_ls_q, last_ls_d;
  logic gif, gls, sel_valid, abort, done, tie_ls;
  assign gif       = state_q == ARB_GNT_IF;
  assign gls       = state_q == ARB_GNT_LS;
  assign sel_valid = (gif && if_valid_i) || (gls && ls_valid_i);
  assign done      = sel_valid && (mem_ready_i || abort);
  arb_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdg (
    .clk  (clk),
    .rst_n(rst_n),
    .busy (sel_valid),
    .ready(mem_ready_i),
    .abort(abort)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ARB_IDLE;
      last_ls_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      last_ls_q <= last_ls_d;
    end
  end
  // Round-robin favours whoever was not served last; the completer is never re-granted directly
  always_comb begin
    tie_ls    = (ARB_MODE == ARB_LS_PRIO) || !last_ls_q;
    idle_d    = (ls_valid_i && (!if_valid_i || tie_ls)) ? ARB_GNT_LS :
                if_valid_i ? ARB_GNT_IF : ARB_IDLE;
    other_d   = gif ? (ls_valid_i ? ARB_GNT_LS : ARB_IDLE) :
                      (if_valid_i ? ARB_GNT_IF : ARB_IDLE);
    state_d   = (state_q == ARB_IDLE) ? idle_d :
                !sel_valid ? ARB_IDLE :
                done ? other_d : state_q;
    last_ls_d = done ? gls : last_ls_q;
  end
  assign mem_valid_o = sel_valid && !abort;
  assign mem_addr_o  = gls ? ls_addr_i  : gif ? if_addr_i  : '0;
  assign mem_wdata_o = gls ? ls_wdata_i : gif ? if_wdata_i : '0;
  assign mem_we_o    = gls ? ls_we_i    : gif ? if_we_i    : '0;
  assign if_ready_o  = gif && if_valid_i && (mem_ready_i || abort);
  assign ls_ready_o  = gls && ls_valid_i && (mem_ready_i || abort);
  assign if_err_o    = gif && abort;
  assign ls_err_o    = gls && abort;
  assign if_rdata_o  = mem_rdata_i;
  assign ls_rdata_o  = mem_rdata_i;
  assign grant_o     = state_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of a round-robin and a data-priority arbiter sharing stimulus
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  logic if_valid, ls_valid, mem_ready;
  logic [31:0] if_addr, if_wdata, ls_addr, ls_wdata, mem_rdata;
  logic [3:0] if_we, ls_we;
  logic if_ready [2];
  logic ls_ready [2];
  logic if_err [2];
  logic ls_err [2];
  logic mem_valid [2];
  logic [31:0] if_rdata [2];
  logic [31:0] ls_rdata [2];
  logic [31:0] mem_addr [2];
  logic [31:0] mem_wdata [2];
  logic [3:0] mem_we [2];
  logic [1:0] grant [2];
  int passed = 0;
  int total = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ARB_MODE(g), .TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_valid_i(if_valid), .if_ready_o(if_ready[g]), .if_addr_i(if_addr),
      .if_wdata_i(if_wdata), .if_we_i(if_we), .if_rdata_o(if_rdata[g]), .if_err_o(if_err[g]),
      .ls_valid_i(ls_valid), .ls_ready_o(ls_ready[g]), .ls_addr_i(ls_addr),
      .ls_wdata_i(ls_wdata), .ls_we_i(ls_we), .ls_rdata_o(ls_rdata[g]), .ls_err_o(ls_err[g]),
      .mem_valid_o(mem_valid[g]), .mem_ready_i(mem_ready), .mem_addr_o(mem_addr[g]),
      .mem_wdata_o(mem_wdata[g]), .mem_we_o(mem_we[g]), .mem_rdata_i(mem_rdata),
      .grant_o(grant[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic idle_chk(input string tag, input int d);
    chk({tag, " grant"}, 32'(grant[d]), 32'h0);
    chk({tag, " mem_valid"}, 32'(mem_valid[d]), 32'h0);
    chk({tag, " if_ready"}, 32'(if_ready[d]), 32'h0);
    chk({tag, " ls_ready"}, 32'(ls_ready[d]), 32'h0);
    chk({tag, " if_err"}, 32'(if_err[d]), 32'h0);
    chk({tag, " ls_err"}, 32'(ls_err[d]), 32'h0);
    chk({tag, " mem_addr"}, mem_addr[d], 32'h0);
  endtask

  task automatic cyc;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; if_valid = 0; ls_valid = 0; mem_ready = 0;
    if_addr = 0; if_wdata = 0; if_we = 0; ls_addr = 0; ls_wdata = 0; ls_we = 0; mem_rdata = 0;
    cyc; cyc; #1;
    idle_chk("rst0", 0);
    idle_chk("rst1", 1);
    rst_n = 1'b1;

    // tie from reset with single-cycle ready
    cyc;
    if_valid = 1; ls_valid = 1; mem_ready = 1;
    if_addr = 32'h10; ls_addr = 32'h20; ls_we = 4'b0011; ls_wdata = 32'h1234_5678;
    #1;
    chk("tie idle grant0", 32'(grant[0]), 32'h0);
    chk("tie idle mem_valid0", 32'(mem_valid[0]), 32'h0);
    cyc; #1;
    chk("rr c1 grant", 32'(grant[0]), 32'h1);
    chk("rr c1 if_ready", 32'(if_ready[0]), 32'h1);
    chk("rr c1 ls_ready", 32'(ls_ready[0]), 32'h0);
    chk("rr c1 addr", mem_addr[0], 32'h10);
    chk("lp c1 grant", 32'(grant[1]), 32'h2);
    chk("lp c1 addr", mem_addr[1], 32'h20);
    chk("lp c1 we", 32'(mem_we[1]), 32'h3);
    chk("lp c1 wdata", mem_wdata[1], 32'h1234_5678);
    chk("lp c1 ls_ready", 32'(ls_ready[1]), 32'h1);
    chk("lp c1 if_ready", 32'(if_ready[1]), 32'h0);
    cyc; #1;
    chk("rr c2 grant", 32'(grant[0]), 32'h2);
    chk("rr c2 addr", mem_addr[0], 32'h20);
    chk("lp c2 grant", 32'(grant[1]), 32'h1);
    cyc; #1;
    chk("rr c3 grant", 32'(grant[0]), 32'h1);
    chk("lp c3 grant", 32'(grant[1]), 32'h2);
    cyc; #1;
    chk("rr c4 grant", 32'(grant[0]), 32'h2);
    cyc;
    if_valid = 0; ls_valid = 0; mem_ready = 0; ls_we = 0; ls_wdata = 0;
    #1;
    chk("tie drop mem_valid0", 32'(mem_valid[0]), 32'h0);
    chk("tie drop if_ready0", 32'(if_ready[0]), 32'h0);
    cyc; #1;
    idle_chk("tie end0", 0);
    idle_chk("tie end1", 1);

    // fetch-only read, ready on second granted cycle
    if_valid = 1; if_addr = 32'h100;
    #1;
    chk("rd idle grant", 32'(grant[0]), 32'h0);
    cyc; #1;
    chk("rd g1 grant", 32'(grant[0]), 32'h1);
    chk("rd g1 mem_valid", 32'(mem_valid[0]), 32'h1);
    chk("rd g1 addr", mem_addr[0], 32'h100);
    chk("rd g1 if_ready", 32'(if_ready[0]), 32'h0);
    cyc;
    mem_ready = 1; mem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("rd g2 if_ready", 32'(if_ready[0]), 32'h1);
    chk("rd g2 if_rdata", if_rdata[0], 32'hDEAD_BEEF);
    chk("rd g2 ls_rdata mirror", ls_rdata[1], 32'hDEAD_BEEF);
    chk("rd g2 ls_ready", 32'(ls_ready[0]), 32'h0);
    chk("rd g2 if_err", 32'(if_err[0]), 32'h0);
    cyc;
    if_valid = 0; mem_ready = 0; mem_rdata = 0;
    #1;
    idle_chk("rd end0", 0);

    // watchdog abort on a data request
    ls_valid = 1; ls_addr = 32'h40;
    cyc;
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk($sformatf("wd g%0d mem_valid", i), 32'(mem_valid[0]), 32'h1);
      chk($sformatf("wd g%0d ls_ready", i), 32'(ls_ready[0]), 32'h0);
      chk($sformatf("wd g%0d ls_err", i), 32'(ls_err[0]), 32'h0);
      cyc;
    end
    #1;
    chk("wd abort mem_valid", 32'(mem_valid[0]), 32'h0);
    chk("wd abort ls_ready", 32'(ls_ready[0]), 32'h1);
    chk("wd abort ls_err", 32'(ls_err[0]), 32'h1);
    chk("wd abort ls_err1", 32'(ls_err[1]), 32'h1);
    cyc;
    ls_valid = 0;
    #1;
    idle_chk("wd end0", 0);

    // ready arriving in the abort cycle completes normally
    ls_valid = 1;
    cyc;
    for (int i = 1; i <= 4; i++) cyc;
    mem_ready = 1;
    #1;
    chk("wdv ls_ready", 32'(ls_ready[0]), 32'h1);
    chk("wdv ls_err", 32'(ls_err[0]), 32'h0);
    chk("wdv mem_valid", 32'(mem_valid[0]), 32'h1);
    cyc;
    ls_valid = 0; mem_ready = 0;
    #1;
    idle_chk("wdv end0", 0);

    // fetch withdraws valid in its second granted cycle
    if_valid = 1; if_addr = 32'h200;
    cyc; #1;
    chk("wd1 grant", 32'(grant[0]), 32'h1);
    cyc;
    if_valid = 0;
    #1;
    chk("wd2 mem_valid", 32'(mem_valid[0]), 32'h0);
    chk("wd2 if_ready", 32'(if_ready[0]), 32'h0);
    chk("wd2 if_err", 32'(if_err[0]), 32'h0);
    cyc; #1;
    idle_chk("wd3", 0);
    ls_valid = 1; mem_ready = 1; ls_addr = 32'h44;
    cyc; #1;
    chk("wd next grant", 32'(grant[0]), 32'h2);
    chk("wd next ls_ready", 32'(ls_ready[0]), 32'h1);
    cyc;
    ls_valid = 0; mem_ready = 0;
    #1;
    idle_chk("wd next end", 0);

    // reset during a stalled grant
    if_valid = 1;
    cyc; #1;
    chk("mr grant", 32'(grant[0]), 32'h1);
    chk("mr mem_valid", 32'(mem_valid[0]), 32'h1);
    rst_n = 0;
    cyc; #1;
    idle_chk("mr rst0", 0);
    idle_chk("mr rst1", 1);
    rst_n = 1; ls_valid = 1;
    cyc; #1;
    chk("mr tie rr grant", 32'(grant[0]), 32'h1);
    chk("mr tie lp grant", 32'(grant[1]), 32'h2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
